demux_stream_1to4: RTL and testbench

Registered 1-to-4 stream demultiplexer with valid/ready handshaking. It routes each accepted input word to one of four output channels, chosen either by an explicit select or by an internal round-robin pointer. Each channel holds its word in a one-entry buffer until its consumer accepts it. It is the clocked, back-pressured successor to the combinational 1x2 demux and sits between a single producer and four independent consumers.

---
 rtl/demux_stream_1to4.sv | 69 ++++++
 tb/tb_demux_stream_1to4.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/demux_stream_1to4.sv
// rtl/demux_stream_1to4.sv - registered 1-to-4 stream demultiplexer with per-channel one-entry buffers
// Words go to in_sel (mode=0) or the round-robin pointer (mode=1); a full, non-draining target stalls the input.
module demux_stream_1to4 #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_sel,
   input  logic             mode,
   output logic [WIDTH-1:0] y0,
   output logic [WIDTH-1:0] y1,
   output logic [WIDTH-1:0] y2,
   output logic [WIDTH-1:0] y3,
   output logic [3:0]       y_valid,
   input  logic [3:0]       y_ready,
   output logic [1:0]       rr_ptr,
   output logic [15:0]      acc_count
);

   logic [3:0]       vld;
   logic [WIDTH-1:0] data_q [4];
   logic [1:0]       target;
   logic [3:0]       drain;
   logic [3:0]       load;
   logic             accept;

   // A full target may still accept when its consumer takes the old word on the same edge.
   always_comb begin
      target   = mode ? rr_ptr : in_sel;
      drain    = vld & y_ready;
      in_ready = ~vld[target] | drain[target];
      accept   = in_valid & in_ready;
      load     = accept ? (4'b0001 << target) : 4'b0000;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld       <= 4'b0000;
         rr_ptr    <= 2'd0;
         acc_count <= 16'd0;
         for (int n = 0; n < 4; n++) begin
            data_q[n] <= '0;
         end
      end else begin
         vld <= (vld & ~drain) | load;
         for (int n = 0; n < 4; n++) begin
            if (load[n]) begin
               data_q[n] <= in_data;
            end
         end
         if (accept) begin
            acc_count <= acc_count + 16'd1;
            if (mode) begin
               rr_ptr <= rr_ptr + 2'd1;
            end
         end
      end
   end

   assign y_valid = vld;
   assign y0      = data_q[0];
   assign y1      = data_q[1];
   assign y2      = data_q[2];
   assign y3      = data_q[3];

endmodule

// File: tb/tb_demux_stream_1to4.sv
// tb/tb_demux_stream_1to4.sv - table vectors plus randomized traffic against a behavioural model
// Model keeps per-channel occupancy/data arrays and applies the routing rules directly.
module tb_demux_stream_1to4;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_sel;
   logic        mode;
   logic [7:0]  y0, y1, y2, y3;
   logic [3:0]  y_valid;
   logic [3:0]  y_ready;
   logic [1:0]  rr_ptr;
   logic [15:0] acc_count;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   demux_stream_1to4 #(.WIDTH(8)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .in_sel(in_sel), .mode(mode), .y0(y0), .y1(y1), .y2(y2), .y3(y3),
      .y_valid(y_valid), .y_ready(y_ready), .rr_ptr(rr_ptr), .acc_count(acc_count)
   );

   typedef struct {
      logic        rst;
      logic        iv;
      logic [7:0]  d;
      logic [1:0]  sel;
      logic        mode;
      logic [3:0]  yr;
      logic        e_inr;
      logic [3:0]  e_yv;
      logic [1:0]  e_rr;
      logic [15:0] e_cnt;
      int          ch;
      logic [7:0]  e_dat;
   } vec_t;

   vec_t vq[$];

   // behavioural reference state
   bit       m_vld [4];
   bit [7:0] m_dat [4];
   int       m_rr;
   int       m_cnt;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] ych(input int n);
      case (n)
         0:       return y0;
         1:       return y1;
         2:       return y2;
         default: return y3;
      endcase
   endfunction

   task automatic drive(input logic r, input logic iv, input logic [7:0] d,
                        input logic [1:0] sel, input logic md, input logic [3:0] yr);
      rst = r; in_valid = iv; in_data = d; in_sel = sel; mode = md; y_ready = yr;
   endtask

   task automatic model_reset();
      for (int n = 0; n < 4; n++) begin
         m_vld[n] = 0;
         m_dat[n] = 0;
      end
      m_rr  = 0;
      m_cnt = 0;
   endtask

   // one cycle through the model: check in_ready before the edge, everything after it
   task automatic model_cycle(input logic r, input logic iv, input logic [7:0] d,
                              input logic [1:0] sel, input logic md, input logic [3:0] yr);
      int  t;
      bit  rdy;
      drive(r, iv, d, sel, md, yr);
      t   = md ? m_rr : int'(sel);
      rdy = !m_vld[t] || yr[t];
      #1;
      check("rand_in_ready", {31'd0, in_ready}, {31'd0, rdy});
      if (r) begin
         model_reset();
      end else begin
         for (int n = 0; n < 4; n++) begin
            if (m_vld[n] && yr[n]) m_vld[n] = 0;
         end
         if (iv && rdy) begin
            m_vld[t] = 1;
            m_dat[t] = d;
            m_cnt    = (m_cnt + 1) % 65536;
            if (md) m_rr = (m_rr + 1) % 4;
         end
      end
      @(posedge clk);
      #1;
      check("rand_y_valid", {28'd0, y_valid}, {28'd0, m_vld[3], m_vld[2], m_vld[1], m_vld[0]});
      check("rand_rr_ptr", {30'd0, rr_ptr}, m_rr);
      check("rand_acc_count", {16'd0, acc_count}, m_cnt);
      for (int n = 0; n < 4; n++) begin
         check("rand_y_data", {24'd0, ych(n)}, {24'd0, m_dat[n]});
      end
   endtask

   initial begin
      drive(1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 4'b0000);
      repeat (2) @(posedge clk);
      #1;

      //             rst iv d      sel mode yr       inr yv       rr cnt   ch data
      vq.push_back('{1, 0, 8'h00, 0, 0, 4'b0000, 1, 4'b0000, 0, 0,  -1, 8'h00});
      vq.push_back('{0, 0, 8'h00, 0, 0, 4'b0000, 1, 4'b0000, 0, 0,  -1, 8'h00});
      vq.push_back('{0, 1, 8'hA0, 3, 0, 4'b1111, 1, 4'b1000, 0, 1,   3, 8'hA0});
      vq.push_back('{0, 1, 8'hA1, 2, 0, 4'b1111, 1, 4'b0100, 0, 2,   2, 8'hA1});
      vq.push_back('{0, 1, 8'hA2, 1, 0, 4'b1111, 1, 4'b0010, 0, 3,   1, 8'hA2});
      vq.push_back('{0, 1, 8'hA3, 0, 0, 4'b1111, 1, 4'b0001, 0, 4,   0, 8'hA3});
      vq.push_back('{0, 1, 8'h10, 0, 1, 4'b1111, 1, 4'b0001, 1, 5,   0, 8'h10});
      vq.push_back('{0, 1, 8'h11, 0, 1, 4'b1111, 1, 4'b0010, 2, 6,   1, 8'h11});
      vq.push_back('{0, 1, 8'h12, 0, 1, 4'b1111, 1, 4'b0100, 3, 7,   2, 8'h12});
      vq.push_back('{0, 1, 8'h13, 0, 1, 4'b1111, 1, 4'b1000, 0, 8,   3, 8'h13});
      vq.push_back('{0, 1, 8'h14, 0, 1, 4'b1111, 1, 4'b0001, 1, 9,   0, 8'h14});
      vq.push_back('{0, 1, 8'h15, 0, 1, 4'b1111, 1, 4'b0010, 2, 10,  1, 8'h15});
      vq.push_back('{0, 0, 8'h00, 0, 1, 4'b1111, 1, 4'b0000, 2, 10, -1, 8'h00});
      // back-pressure on channel 1, rr_ptr held in addressed mode
      vq.push_back('{0, 1, 8'h55, 1, 0, 4'b1101, 1, 4'b0010, 2, 11,  1, 8'h55});
      vq.push_back('{0, 1, 8'h66, 1, 0, 4'b1101, 0, 4'b0010, 2, 11,  1, 8'h55});
      vq.push_back('{0, 1, 8'h66, 1, 0, 4'b1111, 1, 4'b0010, 2, 12,  1, 8'h66});
      vq.push_back('{0, 0, 8'h00, 1, 0, 4'b1111, 1, 4'b0000, 2, 12, -1, 8'h00});
      // bring rr_ptr round to 0, then fill channel 0 and check no skip
      vq.push_back('{0, 1, 8'h20, 0, 1, 4'b1111, 1, 4'b0100, 3, 13,  2, 8'h20});
      vq.push_back('{0, 1, 8'h21, 0, 1, 4'b1111, 1, 4'b1000, 0, 14,  3, 8'h21});
      vq.push_back('{0, 1, 8'h30, 0, 0, 4'b1110, 1, 4'b0001, 0, 15,  0, 8'h30});
      vq.push_back('{0, 1, 8'h31, 0, 1, 4'b1110, 0, 4'b0001, 0, 15,  0, 8'h30});
      vq.push_back('{0, 1, 8'h31, 0, 1, 4'b1110, 0, 4'b0001, 0, 15,  0, 8'h30});
      vq.push_back('{0, 1, 8'h31, 0, 1, 4'b1111, 1, 4'b0001, 1, 16,  0, 8'h31});
      // fill all four, then reset with traffic pending
      vq.push_back('{0, 1, 8'h41, 1, 0, 4'b0000, 1, 4'b0011, 1, 17,  1, 8'h41});
      vq.push_back('{0, 1, 8'h42, 2, 0, 4'b0000, 1, 4'b0111, 1, 18,  2, 8'h42});
      vq.push_back('{0, 1, 8'h43, 3, 0, 4'b0000, 1, 4'b1111, 1, 19,  3, 8'h43});
      vq.push_back('{1, 1, 8'h99, 0, 0, 4'b1111, 1, 4'b0000, 0, 0,   0, 8'h00});
      vq.push_back('{0, 0, 8'h00, 0, 0, 4'b0000, 1, 4'b0000, 0, 0,   3, 8'h00});

      for (int i = 0; i < vq.size(); i++) begin
         drive(vq[i].rst, vq[i].iv, vq[i].d, vq[i].sel, vq[i].mode, vq[i].yr);
         #1;
         check($sformatf("vec%0d_in_ready", i), {31'd0, in_ready}, {31'd0, vq[i].e_inr});
         @(posedge clk);
         #1;
         check($sformatf("vec%0d_y_valid", i), {28'd0, y_valid}, {28'd0, vq[i].e_yv});
         check($sformatf("vec%0d_rr_ptr", i), {30'd0, rr_ptr}, {30'd0, vq[i].e_rr});
         check($sformatf("vec%0d_acc_count", i), {16'd0, acc_count}, {16'd0, vq[i].e_cnt});
         if (vq[i].ch >= 0) begin
            check($sformatf("vec%0d_y%0d", i, vq[i].ch), {24'd0, ych(vq[i].ch)}, {24'd0, vq[i].e_dat});
         end
      end

      // sustained round-robin burst: one word per cycle with all consumers ready
      model_cycle(1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 4'b0000);
      for (int i = 0; i < 12; i++) begin
         model_cycle(1'b0, 1'b1, 8'(8'hC0 + i), 2'd0, 1'b1, 4'b1111);
      end

      // randomized traffic
      begin
         logic md = 1'b0;
         for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) md = ~md;
            model_cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
                        8'($urandom), 2'($urandom), md, 4'($urandom));
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
